// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with debounce and valid/ready press events.
// Optional auto-repeat of a held key when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic [3:0] held_code,
    output logic       overrun
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB     = 2'd1,
        PRESSED = 2'd2,
        REL     = 2'd3
    } state_t;

    function automatic logic [1:0] low_col(input logic [3:0] c);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!c[i]) r = i[1:0];
        end
        return r;
    endfunction

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [DW-1:0] div;
    logic [1:0]    row_idx;
    logic          acc_hit;
    logic [3:0]    acc_code;

    logic          slot_end;
    logic          frame_end;
    logic          row_hit;
    logic [3:0]    row_code;
    logic          fr_hit;
    logic [3:0]    fr_code;

    assign slot_end  = (div == DW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (row_idx == 2'd3);
    assign row_hit   = (sync2 != 4'hF);
    assign row_code  = {row_idx, low_col(sync2)};
    // Earlier rows win; row 3 only counts when nothing was seen before it.
    assign fr_hit    = acc_hit | row_hit;
    assign fr_code   = acc_hit ? acc_code : row_code;

    // Column synchronizer, slot divider, row rotation and per-frame key capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 4'hF;
            sync2    <= 4'hF;
            div      <= '0;
            row_idx  <= 2'd0;
            row      <= 4'b1110;
            acc_hit  <= 1'b0;
            acc_code <= 4'd0;
        end else begin
            sync1 <= col;
            sync2 <= sync1;
            if (slot_end) begin
                div     <= '0;
                row_idx <= row_idx + 2'd1;
                row     <= {row[2:0], row[3]};
                if (frame_end) begin
                    acc_hit  <= 1'b0;
                    acc_code <= 4'd0;
                end else if (!acc_hit && row_hit) begin
                    acc_hit  <= 1'b1;
                    acc_code <= row_code;
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    state_t     state;
    state_t     state_n;
    logic [3:0] cand;
    logic [3:0] cnt;
    logic [3:0] rcnt;
    logic       same;
    logic       deb_done;
    logic       rel_done;

    logic       cand_ld;
    logic       cnt_inc;
    logic       rcnt_set;
    logic       rcnt_inc;
    logic       press;
    logic       release_k;
    logic       rep_fire;

    assign same     = fr_hit && (fr_code == cand);
    assign deb_done = (cnt == 4'(DEBOUNCE_FRAMES - 1));
    assign rel_done = (rcnt == 4'(DEBOUNCE_FRAMES - 1));

    // Debounce state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Debounce next-state, advanced only at frame end
    always_comb begin
        state_n = state;
        if (frame_end) begin
            unique case (state)
                IDLE:    if (fr_hit) state_n = DEB;
                DEB: begin
                    if (!fr_hit)               state_n = IDLE;
                    else if (same && deb_done) state_n = PRESSED;
                end
                PRESSED: if (!same) state_n = REL;
                REL: begin
                    if (same)          state_n = PRESSED;
                    else if (rel_done) state_n = IDLE;
                end
            endcase
        end
    end

    // Debounce control strobes for the datapath
    always_comb begin
        cand_ld   = 1'b0;
        cnt_inc   = 1'b0;
        rcnt_set  = 1'b0;
        rcnt_inc  = 1'b0;
        press     = 1'b0;
        release_k = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: cand_ld = fr_hit;
                DEB: begin
                    if (fr_hit && !same) cand_ld = 1'b1;
                    else if (same && deb_done) press = 1'b1;
                    else if (same) cnt_inc = 1'b1;
                end
                PRESSED: rcnt_set = !same;
                REL: begin
                    if (!same && rel_done) release_k = 1'b1;
                    else if (!same) rcnt_inc = 1'b1;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [7:0] rep_cnt;
    logic       hold;

    assign hold     = frame_end && (state == PRESSED) && same;
    assign rep_fire = hold && (rep_cnt == 8'(REPEAT_FRAMES - 1));

    // Repeat timer: restarts on a fresh press, keeps its count across a REL dip
    always_ff @(posedge clk) begin
        if (!rst_n)        rep_cnt <= 8'd0;
        else if (press)    rep_cnt <= 8'd0;
        else if (rep_fire) rep_cnt <= 8'd0;
        else if (hold)     rep_cnt <= rep_cnt + 8'd1;
    end
`else
    assign rep_fire = 1'b0;
`endif

    logic       evt;
    logic [3:0] evt_code;

    // Candidate, frame counters, held key and one-cycle event request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand      <= 4'd0;
            cnt       <= 4'd0;
            rcnt      <= 4'd0;
            key_down  <= 1'b0;
            held_code <= 4'd0;
            evt       <= 1'b0;
            evt_code  <= 4'd0;
        end else begin
            evt <= press | rep_fire;
            if (press)         evt_code <= cand;
            else if (rep_fire) evt_code <= held_code;
            if (cand_ld) begin
                cand <= fr_code;
                cnt  <= 4'd1;
            end else if (cnt_inc) begin
                cnt <= cnt + 4'd1;
            end
            if (rcnt_set)      rcnt <= 4'd1;
            else if (rcnt_inc) rcnt <= rcnt + 4'd1;
            if (press) begin
                key_down  <= 1'b1;
                held_code <= cand;
            end else if (release_k) begin
                key_down <= 1'b0;
            end
        end
    end

    // Event handshake: load, drop on busy (sticky overrun), or retire on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            overrun   <= 1'b0;
        end else if (evt) begin
            if (!key_valid || key_ready) begin
                key_valid <= 1'b1;
                key_code  <= evt_code;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: random key-matrix stimulus against a frame-level model.
// Default build (auto-repeat disabled), SCAN_DIV=4, DEBOUNCE_FRAMES=4.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DB  = 4;
    localparam int FRM = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_down;
    logic [3:0]  held_code;
    logic        overrun;
    logic [15:0] mask = 16'h0;

    int vecs = 0;
    int errs = 0;

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_FRAMES(DB),
        .REPEAT_FRAMES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_down(key_down),
        .held_code(held_code),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row[r])
                for (int c = 0; c < 4; c++)
                    if (mask[r*4+c]) col[c] = 1'b0;
    end

    // Model state
    int k;
    bit m_valid, m_ovr, m_down, m_pend;
    int m_code, m_held, m_pcode, m_cand, m_run, m_gap;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at k=%0d: got %0d want %0d", tag, k, got, exp);
        end
    endtask

    function automatic int frame_key(input logic [15:0] m);
        for (int i = 0; i < 16; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        k = 0;
        m_valid = 0; m_ovr = 0; m_down = 0; m_pend = 0;
        m_code = 0; m_held = 0; m_pcode = 0;
        m_cand = -1; m_run = 0; m_gap = 0;
    endtask

    // Run-length view of debounce: count identical frames up / mismatches up
    task automatic debounce(input int r);
        if (!m_down) begin
            if (r < 0) m_run = 0;
            else if (m_run > 0 && r == m_cand) m_run++;
            else begin
                m_cand = r;
                m_run  = 1;
            end
            if (m_run == DB) begin
                m_down  = 1;
                m_held  = m_cand;
                m_gap   = 0;
                m_pend  = 1;
                m_pcode = m_cand;
            end
        end else begin
            if (r == m_held) m_gap = 0;
            else begin
                m_gap++;
                if (m_gap == DB) begin
                    m_down = 0;
                    m_run  = 0;
                end
            end
        end
    endtask

    task automatic model_edge(input bit rdy);
        k++;
        if (m_pend) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_code  = m_pcode;
            end else begin
                m_ovr = 1;
            end
            m_pend = 0;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (k % FRM == 0) debounce(frame_key(mask));
    endtask

    task automatic check_all();
        logic [3:0] er;
        er = 4'hF;
        er[(k / SD) % 4] = 1'b0;
        check("row", row, er);
        check("key_valid", key_valid, m_valid);
        check("key_code", key_code, m_code);
        check("key_down", key_down, m_down);
        if (m_down) check("held_code", held_code, m_held);
        check("overrun", overrun, m_ovr);
    endtask

    task automatic cycle(input int mode);
        @(posedge clk);
        model_edge(key_ready);
        #1;
        check_all();
        key_ready = (mode == 2) ? 1'($urandom % 2) : 1'(mode);
    endtask

    task automatic run_seg(input logic [15:0] m, input int frames,
                           input int mode);
        mask = m;
        repeat (frames * FRM) cycle(mode);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] m;
        int          sel;
        model_reset();
        key_ready = 1'b0;
        do_reset();

        run_seg(16'h0, 1, 0);
        run_seg(16'h0200, 6, 1);
        run_seg(16'h0, 5, 1);
        run_seg(16'h0200, 2, 2);
        run_seg(16'h0, 1, 2);
        run_seg(16'h0200, 5, 2);
        run_seg(16'h0, 5, 1);
        run_seg(16'h0048, 6, 1);
        run_seg(16'h0, 5, 1);

        run_seg(16'h0020, 5, 0);
        mask = 16'h0020;
        repeat (7) cycle(0);
        do_reset();

        run_seg(16'h0001, 6, 0);
        run_seg(16'h0, 5, 0);
        run_seg(16'h8000, 6, 0);
        run_seg(16'h0, 2, 1);

        do_reset();
        m = 16'h0;
        for (int s = 0; s < 140; s++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: m = 16'h0;
                1, 2: m = 16'h1 << $urandom_range(0, 15);
                3: m = (16'h1 << $urandom_range(0, 15)) |
                       (16'h1 << $urandom_range(0, 15));
                default: ;
            endcase
            run_seg(m, $urandom_range(1, 8),
                    (s < 120) ? $urandom_range(1, 2) : $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
